multicycle_control: RTL and testbench

- Sequential successor to the single-cycle decoder.
- Drives a multi-cycle RISC-V datapath through the FETCH, DECODE, EXEC, MEM and WB phases.
- Fetch and data accesses use a req/ready handshake to the shared memory port.
- Supports addi, lw, sw, beq and bne; any other opcode is illegal and halts the core.

---
 rtl/multicycle_control.sv | 112 +++++++++++
 tb/tb_multicycle_control.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: FSM sequencing a multi-cycle RISC-V datapath (addi/lw/sw/beq/bne).
// Define MULTICYCLE_RETIRE_CNT_EN to build the retired-instruction counter.
module multicycle_control #(
    parameter int OPCODE_W  = 7,
    parameter int ALUCTRL_W = 3,
    parameter int IMMSRC_W  = 2,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [OPCODE_W-1:0]  instr_opcode,
    input  logic [2:0]           funct3,
    input  logic                 EQ,
    input  logic                 mem_ready,
    output logic                 MemReq,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 PCsrc,
    output logic                 RegWrite,
    output logic [ALUCTRL_W-1:0] ALUctrl,
    output logic                 ALUsrc,
    output logic [IMMSRC_W-1:0]  ImmSrc,
    output logic                 ResultSrc,
    output logic                 Illegal,
    output logic [CNT_W-1:0]     retired
);
    localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(7'b0010011);
    localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(7'b0000011);
    localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(7'b0100011);
    localparam logic [OPCODE_W-1:0] OP_BR   = OPCODE_W'(7'b1100011);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    state_t              state, state_n;
    logic [OPCODE_W-1:0] op_q;
    logic                is_lw, is_sw, is_br, legal, taken, in_instr;

    assign is_lw    = op_q == OP_LW;
    assign is_sw    = op_q == OP_SW;
    assign is_br    = op_q == OP_BR;
    assign legal    = instr_opcode inside {OP_ADDI, OP_LW, OP_SW, OP_BR};
    assign taken    = is_br && ((funct3 == 3'b000 && EQ) || (funct3 == 3'b001 && !EQ));
    assign in_instr = state inside {EXEC, MEM, WB};

    // Datapath selects stay stable for the rest of the instruction once decoded
    assign ALUctrl = in_instr && is_br ? ALUCTRL_W'(7) : '0;
    assign ALUsrc  = in_instr && !is_br;
    assign ImmSrc  = !in_instr ? '0 : is_sw ? IMMSRC_W'(1) : is_br ? IMMSRC_W'(2) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            op_q    <= '0;
            Illegal <= 1'b0;
        end else begin
            state <= state_n;
            if (state == DECODE) begin
                op_q <= instr_opcode;
                if (!legal) Illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        state_n   = state;
        MemReq    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        PCsrc     = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 1'b0;
        case (state)
            FETCH: begin
                MemReq  = 1'b1;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                state_n = mem_ready ? DECODE : FETCH;
            end
            DECODE: state_n = legal ? EXEC : HALT;
            EXEC: begin
                PCWrite = taken;
                PCsrc   = taken;
                state_n = is_br ? FETCH : (is_lw || is_sw) ? MEM : WB;
            end
            MEM: begin
                MemReq   = 1'b1;
                MemWrite = is_sw;
                state_n  = !mem_ready ? MEM : is_lw ? WB : FETCH;
            end
            WB: begin
                RegWrite  = 1'b1;
                ResultSrc = is_lw;
                state_n   = FETCH;
            end
            default: ;
        endcase
    end

`ifdef MULTICYCLE_RETIRE_CNT_EN
    logic retire;
    assign retire = state == WB || (state == MEM && mem_ready && is_sw) || (state == EXEC && is_br);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) retired <= '0;
        else if (retire) retired <= retired + CNT_W'(1);
    end
`else
    assign retired = '0;
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table, random and hand-written sequences against a phase-list model.
module tb_multicycle_control;
    logic        clk = 1'b0;
    logic        rst_n, EQ, mem_ready;
    logic [6:0]  instr_opcode;
    logic [2:0]  funct3;
    logic        MemReq, MemWrite, IRWrite, PCWrite, PCsrc, RegWrite, ALUsrc, ResultSrc, Illegal;
    logic [2:0]  ALUctrl;
    logic [1:0]  ImmSrc;
    logic [31:0] retired;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .instr_opcode(instr_opcode), .funct3(funct3), .EQ(EQ),
        .mem_ready(mem_ready), .MemReq(MemReq), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCsrc(PCsrc), .RegWrite(RegWrite), .ALUctrl(ALUctrl),
        .ALUsrc(ALUsrc), .ImmSrc(ImmSrc), .ResultSrc(ResultSrc), .Illegal(Illegal),
        .retired(retired)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] ADDI = 7'b0010011;
    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] BAD  = 7'b0110111;

    int checks = 0, failures = 0, cyc = 0, last_ir = 0, exp_gap = 0, prev_len = 0, model_ret = 0;

    logic [13:0] outs;
    assign outs = {MemReq, MemWrite, IRWrite, PCWrite, PCsrc, RegWrite, ALUctrl, ALUsrc, ImmSrc, ResultSrc, Illegal};

    typedef struct {logic mr; logic [6:0] op; logic [13:0] exp; string nm;} step_t;
    typedef struct {logic [6:0] op; logic [2:0] f3; logic eq; int fw; int mw; int len;} vec_t;
    step_t q[$];
    vec_t  tab[11];

    function automatic logic [13:0] mk(input logic mreq, mwr, ir, pcw, pcs, rw, input logic [2:0] alu,
                                       input logic asrc, input logic [1:0] imm, input logic rs, ill);
        return {mreq, mwr, ir, pcw, pcs, rw, alu, asrc, imm, rs, ill};
    endfunction

    function automatic logic [31:0] ret_exp(input int n);
`ifdef MULTICYCLE_RETIRE_CNT_EN
        return 32'(n);
`else
        return 32'(n * 0);
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step(input logic mr, input logic [6:0] op, input logic [13:0] exp, input string nm);
        instr_opcode = op;
        mem_ready    = mr;
        #3;
        chk(nm, 32'(outs), 32'(exp));
        if (IRWrite === 1'b1) begin
            if (exp_gap > 0) chk("latency", 32'(cyc - last_ir), 32'(exp_gap));
            last_ir = cyc;
            exp_gap = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Expected behaviour of one legal instruction, phase by phase
    task automatic plan(input logic [6:0] op, input logic [2:0] f3, input logic eq, input int fw, input int mw);
        logic       lw = op == LW, sw = op == SW, br = op == BR;
        logic       tk = br && ((f3 == 3'b000 && eq) || (f3 == 3'b001 && !eq));
        logic [2:0] alu = br ? 3'b111 : 3'b000;
        logic [1:0] imm = sw ? 2'b01 : br ? 2'b10 : 2'b00;
        q.delete();
        repeat (fw) q.push_back('{1'b0, 7'($urandom), mk(1,0,0,0,0,0,0,0,0,0,0), "fetch_wait"});
        q.push_back('{1'b1, 7'($urandom), mk(1,0,1,1,0,0,0,0,0,0,0), "fetch"});
        q.push_back('{1'($urandom), op, mk(0,0,0,0,0,0,0,0,0,0,0), "decode"});
        q.push_back('{1'($urandom), op, mk(0,0,0,tk,tk,0,alu,!br,imm,0,0), "exec"});
        if (lw || sw) begin
            repeat (mw) q.push_back('{1'b0, op, mk(1,sw,0,0,0,0,alu,1,imm,0,0), "mem_wait"});
            q.push_back('{1'b1, op, mk(1,sw,0,0,0,0,alu,1,imm,0,0), "mem"});
        end
        if (!sw && !br) q.push_back('{1'($urandom), op, mk(0,0,0,0,0,1,alu,1,imm,lw,0), "wb"});
        model_ret++;
    endtask

    task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic eq, input int fw, input int mw, input int len);
        chk("retired", retired, ret_exp(model_ret));
        exp_gap  = prev_len > 0 ? prev_len + fw : 0;
        prev_len = len;
        funct3 = f3;
        EQ     = eq;
        plan(op, f3, eq, fw, mw);
        foreach (q[i]) step(q[i].mr, q[i].op, q[i].exp, q[i].nm);
    endtask

    initial begin
        tab = '{'{ADDI, 3'd0, 1'b0, 0, 0, 4}, '{LW, 3'd0, 1'b0, 0, 0, 5}, '{SW, 3'd0, 1'b0, 0, 0, 4},
                '{BR, 3'd0, 1'b1, 0, 0, 3}, '{BR, 3'd1, 1'b0, 0, 0, 3}, '{BR, 3'd1, 1'b1, 0, 0, 3},
                '{BR, 3'd0, 1'b0, 1, 0, 3}, '{LW, 3'd2, 1'b0, 0, 3, 8}, '{SW, 3'd0, 1'b0, 2, 2, 6},
                '{BR, 3'd5, 1'b1, 0, 0, 3}, '{ADDI, 3'd7, 1'b1, 1, 0, 4}};
        rst_n = 1'b0; mem_ready = 1'b0; EQ = 1'b0; funct3 = 3'd0; instr_opcode = 7'd0;
        repeat (2) @(posedge clk);
        #3;
        chk("reset_outs", 32'(outs), 32'(mk(1,0,0,0,0,0,0,0,0,0,0)));
        chk("reset_retired", retired, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (tab[i]) run(tab[i].op, tab[i].f3, tab[i].eq, tab[i].fw, tab[i].mw, tab[i].len);

        for (int i = 0; i < 40; i++) begin
            logic [6:0] op;
            logic [2:0] f3;
            int mw;
            case ($urandom_range(0, 3))
                0: op = ADDI;
                1: op = LW;
                2: op = SW;
                default: op = BR;
            endcase
            f3 = $urandom_range(0, 3) == 0 ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 1));
            mw = $urandom_range(0, 3);
            run(op, f3, 1'($urandom), $urandom_range(0, 2), mw,
                op == ADDI ? 4 : op == LW ? 5 + mw : op == SW ? 4 + mw : 3);
        end

        // Asynchronous reset while lw waits in MEM
        chk("retired", retired, ret_exp(model_ret));
        funct3 = 3'd0; EQ = 1'b0; exp_gap = 0; prev_len = 0;
        plan(LW, 3'd0, 1'b0, 0, 3);
        for (int i = 0; i < 4; i++) step(q[i].mr, q[i].op, q[i].exp, q[i].nm);
        rst_n = 1'b0;
        #2;
        chk("rst_mid_lw_outs", 32'(outs), 32'(mk(1,0,0,0,0,0,0,0,0,0,0)));
        chk("rst_mid_lw_retired", retired, 32'd0);
        model_ret = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, LW, mk(1,0,0,0,0,0,0,0,0,0,0), "post_rst_no_regwrite");

        run(ADDI, 3'd0, 1'b0, 0, 0, 4);
        run(SW, 3'd0, 1'b0, 0, 1, 5);
        run(BR, 3'd0, 1'b1, 0, 0, 3);
        run(LW, 3'd0, 1'b0, 0, 0, 5);
        chk("retired_after_4", retired, ret_exp(4));

        // Illegal opcode halts with no strobes until reset
        exp_gap = 0;
        step(1'b1, 7'($urandom), mk(1,0,1,1,0,0,0,0,0,0,0), "ill_fetch");
        step(1'b1, BAD, mk(0,0,0,0,0,0,0,0,0,0,0), "ill_decode");
        for (int i = 0; i < 20; i++) step(1'($urandom), BAD, mk(0,0,0,0,0,0,0,0,0,0,1), "halt");
        rst_n = 1'b0;
        #2;
        chk("illegal_cleared", 32'(outs), 32'(mk(1,0,0,0,0,0,0,0,0,0,0)));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, ADDI, mk(1,0,0,0,0,0,0,0,0,0,0), "fetch_after_halt");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
